// File: rtl/event_readout_ctrl.sv
// Event readout controller.
// Accepts an event from the sampler over the event_ready/event_saved handshake,
// latches the payload locally and streams it out as a framed 32-bit
// AXI-Stream packet: header, timestamp, channel data words, trailer.
// While disabled, events are still acknowledged and counted as dropped so
// the sampler never stalls.
//
// Ports:
//   clk, aresetn       clock, asynchronous active-low reset
//   enable             readout enable, sampled only in IDLE
//   event_ready        sampler has a valid event held on evento
//   evento             event payload, CHANNELS x SAMPLES bits
//   event_saved        one-cycle acknowledge back to the sampler
//   m_tdata/m_tvalid/m_tready/m_tlast   AXI-Stream master
//   event_count        packets fully transmitted (wraps)
//   dropped_count      events acknowledged while disabled (saturates)
//   busy               high whenever the controller is not idle
module event_readout_ctrl #(
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned SAMPLES  = 64
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic                              enable,
    input  logic                              event_ready,
    input  logic [CHANNELS-1:0][SAMPLES-1:0]  evento,
    output logic                              event_saved,
    output logic [31:0]                       m_tdata,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic                              m_tlast,
    output logic [23:0]                       event_count,
    output logic [15:0]                       dropped_count,
    output logic                              busy
);

    localparam int unsigned WORDS_PER_CH = SAMPLES / 32;
    localparam int unsigned DATA_WORDS   = CHANNELS * WORDS_PER_CH;
    localparam int unsigned IDX_W        = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam int unsigned BUF_W        = CHANNELS * SAMPLES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_DROP,
        S_HEADER,
        S_TSTAMP,
        S_DATA,
        S_TRAILER
    } state_t;

    state_t              state_q;
    logic [BUF_W-1:0]    buf_q;
    logic [31:0]         ts_cnt_q;
    logic [31:0]         ts_q;
    logic [CHANNELS-1:0] hit_q;
    logic [IDX_W-1:0]    idx_q;
    logic                saved_q;
    logic                tvalid_q;
    logic                tlast_q;
    logic [31:0]         tdata_q;
    logic [23:0]         evcnt_q;
    logic [15:0]         dropcnt_q;
    logic                busy_q;

    logic [CHANNELS-1:0] hit_d;
    logic [IDX_W-1:0]    sel_d;
    logic [IDX_W+4:0]    base_d;
    logic [31:0]         word_d;
    logic                hs_c;

    // Free-running cycle counter used as the event timestamp
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            ts_cnt_q <= 32'd0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 32'd1;
        end
    end

    // Per-channel hit flag: any nonzero sample bit in the channel
    always_comb begin
        hit_d = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            hit_d[c] = |evento[c];
        end
    end

    // Next data word to load into m_tdata. The buffer is laid out so that
    // data word i sits at bits [32*i +: 32] (channel-major, low half first).
    always_comb begin
        sel_d  = '0;
        if (state_q == S_DATA) begin
            sel_d = idx_q + IDX_W'(1);
        end
        base_d = {sel_d, 5'b00000};
        word_d = buf_q[base_d +: 32];
    end

    // m_tvalid is registered, so a transfer completes when the sink is ready
    assign hs_c = tvalid_q && m_tready;

    // Control FSM; all outputs are loaded together with the state transition
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            buf_q     <= '0;
            ts_q      <= 32'd0;
            hit_q     <= '0;
            idx_q     <= '0;
            saved_q   <= 1'b0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= 32'd0;
            evcnt_q   <= 24'd0;
            dropcnt_q <= 16'd0;
            busy_q    <= 1'b0;
        end else begin
            saved_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (event_ready) begin
                        saved_q <= 1'b1;
                        busy_q  <= 1'b1;
                        if (enable) begin
                            buf_q   <= evento;
                            ts_q    <= ts_cnt_q;
                            hit_q   <= hit_d;
                            state_q <= S_ACK;
                        end else begin
                            state_q <= S_DROP;
                        end
                    end
                end
                S_ACK: begin
                    state_q  <= S_HEADER;
                    tvalid_q <= 1'b1;
                    tdata_q  <= {8'hA5, evcnt_q};
                end
                S_DROP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (dropcnt_q != 16'hFFFF) begin
                        dropcnt_q <= dropcnt_q + 16'd1;
                    end
                end
                S_HEADER: begin
                    if (hs_c) begin
                        state_q <= S_TSTAMP;
                        tdata_q <= ts_q;
                    end
                end
                S_TSTAMP: begin
                    if (hs_c) begin
                        state_q <= S_DATA;
                        idx_q   <= '0;
                        tdata_q <= word_d;
                    end
                end
                S_DATA: begin
                    if (hs_c) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_TRAILER;
                            tlast_q <= 1'b1;
                            tdata_q <= {8'h5A, 8'h00, 16'(hit_q)};
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            tdata_q <= word_d;
                        end
                    end
                end
                S_TRAILER: begin
                    if (hs_c) begin
                        state_q  <= S_IDLE;
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        tdata_q  <= 32'd0;
                        busy_q   <= 1'b0;
                        evcnt_q  <= evcnt_q + 24'd1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign event_saved   = saved_q;
    assign m_tdata       = tdata_q;
    assign m_tvalid      = tvalid_q;
    assign m_tlast       = tlast_q;
    assign event_count   = evcnt_q;
    assign dropped_count = dropcnt_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_event_readout_ctrl.sv
// Directed bench for event_readout_ctrl: a sampler model, a sink with optional
// random backpressure, and a stream monitor that logs every accepted word.
module tb_event_readout_ctrl;

    localparam int unsigned CH = 16;
    localparam int unsigned SM = 64;

    logic               clk = 1'b0;
    logic               aresetn;
    logic               enable;
    logic               event_ready;
    logic [CH-1:0][SM-1:0] evento;
    logic               event_saved;
    logic [31:0]        m_tdata;
    logic               m_tvalid;
    logic               m_tready;
    logic               m_tlast;
    logic [23:0]        event_count;
    logic [15:0]        dropped_count;
    logic               busy;

    int n_vec = 0;
    int n_err = 0;

    int   req_cnt = 0;
    logic bp_mode = 1'b0;

    logic [63:0] img [CH];

    logic [32:0] wq [$];
    int          wcyc [$];
    int          saved_cycles = 0;
    int          saved_pulses = 0;
    int          saved_cyc = 0;
    int          words_at_saved = 0;
    logic [31:0] ts_at_saved = 32'd0;

    always #5 clk = ~clk;

    event_readout_ctrl #(
        .CHANNELS (CH),
        .SAMPLES  (SM)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .enable        (enable),
        .event_ready   (event_ready),
        .evento        (evento),
        .event_saved   (event_saved),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tlast       (m_tlast),
        .event_count   (event_count),
        .dropped_count (dropped_count),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input int i);
        logic [63:0] ch;
        ch = img[i / 2];
        return (i % 2 == 1) ? ch[63:32] : ch[31:0];
    endfunction

    // Sampler: raises event_ready per request, drops it the cycle after event_saved
    initial begin : sampler
        int served;
        served = 0;
        event_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (event_ready && event_saved) begin
                @(posedge clk); #1;
                event_ready = 1'b0;
            end else if (!event_ready && served < req_cnt) begin
                @(posedge clk); #1;
                event_ready = 1'b1;
                served++;
            end
        end
    end

    // Sink ready: always 1, or ~30% high under backpressure
    initial begin : sink
        m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_tready = bp_mode ? ($urandom_range(9, 0) < 3) : 1'b1;
        end
    end

    // Monitor: timestamp model, ack bookkeeping, stream logging and protocol checks
    initial begin : monitor
        logic [31:0] ts_model, ts_prev;
        logic [32:0] prev_word;
        bit fresh, in_pkt, prev_stall, prev_saved;
        int ncyc;
        ts_model = 32'd0; ts_prev = 32'd0; prev_word = '0;
        fresh = 1'b1; in_pkt = 1'b0; prev_stall = 1'b0; prev_saved = 1'b0;
        ncyc = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!aresetn) begin
                ts_model   = 32'd0;
                fresh      = 1'b1;
                in_pkt     = 1'b0;
                prev_stall = 1'b0;
                prev_saved = 1'b0;
            end else begin
                if (fresh) fresh = 1'b0;
                else       ts_model = ts_model + 32'd1;
                if (event_saved) begin
                    saved_cycles++;
                    if (!prev_saved) begin
                        saved_pulses++;
                        saved_cyc      = ncyc;
                        ts_at_saved    = ts_prev;
                        words_at_saved = wq.size();
                    end
                end
                prev_saved = event_saved;
                if (prev_stall)
                    chk("stall_hold", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, prev_word}));
                if (in_pkt)
                    chk("valid_gap", 64'(m_tvalid), 64'(1));
                if (m_tvalid && m_tready) begin
                    wq.push_back({m_tlast, m_tdata});
                    wcyc.push_back(ncyc);
                    in_pkt = !m_tlast;
                end
                prev_stall = m_tvalid && !m_tready;
                prev_word  = {m_tlast, m_tdata};
                ts_prev    = ts_model;
            end
        end
    end

    task automatic apply_img();
        for (int c = 0; c < int'(CH); c++) evento[c] = img[c];
    endtask

    task automatic set_pattern_a();
        for (int c = 0; c < int'(CH); c++) img[c] = {32'(c * 2 + 1), 32'(c * 2)};
        apply_img();
    endtask

    task automatic request_event(input string tag, output logic [31:0] ts);
        int p, t;
        p = saved_pulses;
        t = 0;
        req_cnt++;
        while (saved_pulses == p && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_ack"}, 64'(saved_pulses - p), 64'(1));
        ts = ts_at_saved;
    endtask

    task automatic wait_words(input int target, input string tag);
        int t;
        t = 0;
        while (wq.size() < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_words"}, 64'(wq.size() >= target), 64'(1));
    endtask

    task automatic check_packet(input string tag, input int base, input logic [23:0] cnt,
                                input logic [31:0] ts, input logic [15:0] mask);
        chk({tag, "_hdr"}, 64'(wq[base]), 64'({1'b0, 8'hA5, cnt}));
        chk({tag, "_ts"}, 64'(wq[base + 1]), 64'({1'b0, ts}));
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s_d%0d", tag, i), 64'(wq[base + 2 + i]), 64'({1'b0, exp_data(i)}));
        chk({tag, "_trl"}, 64'(wq[base + 34]), 64'({1'b1, 8'h5A, 8'h00, mask}));
    endtask

    initial begin : main
        logic [31:0] ts1, ts2;
        int base, p0, sz, t;

        aresetn = 1'b0;
        enable  = 1'b1;
        evento  = '0;
        for (int c = 0; c < int'(CH); c++) img[c] = '0;
        repeat (2) @(posedge clk); #1;
        chk("rst_ctl", 64'({event_saved, m_tvalid, m_tlast, busy}), 64'(0));
        chk("rst_tdata", 64'(m_tdata), 64'(0));
        chk("rst_cnt", 64'({event_count, dropped_count}), 64'(0));
        aresetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ctl", 64'({event_saved, m_tvalid, m_tlast, busy}), 64'(0));

        // Single event, sink always ready
        set_pattern_a();
        base = wq.size();
        request_event("single", ts1);
        chk("single_busy", 64'(busy), 64'(1));
        wait_words(base + 35, "single");
        check_packet("single", base, 24'd0, ts1, 16'hFFFF);
        chk("single_lat", 64'(wcyc[base] - saved_cyc), 64'(1));
        chk("single_burst", 64'(wcyc[base + 34] - wcyc[base]), 64'(34));
        repeat (3) @(negedge clk);
        chk("single_cnt", 64'(event_count), 64'(1));
        chk("single_len", 64'(wq.size()), 64'(base + 35));
        chk("single_pulse", 64'(saved_cycles), 64'(saved_pulses));
        chk("single_busy_end", 64'(busy), 64'(0));

        // Same event under random backpressure
        base = wq.size();
        bp_mode = 1'b1;
        request_event("bp", ts1);
        wait_words(base + 35, "bp");
        bp_mode = 1'b0;
        check_packet("bp", base, 24'd1, ts1, 16'hFFFF);

        // Second event raised during DATA of the first packet
        repeat (3) @(negedge clk);
        base = wq.size();
        p0 = saved_pulses;
        request_event("b2b1", ts1);
        wait_words(base + 12, "b2b_mid");
        req_cnt++;
        wait_words(base + 70, "b2b");
        ts2 = ts_at_saved;
        chk("b2b_ack2_pos", 64'(words_at_saved), 64'(base + 35));
        chk("b2b_pulses", 64'(saved_pulses - p0), 64'(2));
        check_packet("b2b1", base, 24'd2, ts1, 16'hFFFF);
        check_packet("b2b2", base + 35, 24'd3, ts2, 16'hFFFF);

        // Only channels 3 and 15 carry hits
        repeat (3) @(negedge clk);
        for (int c = 0; c < int'(CH); c++) img[c] = '0;
        img[3]  = 64'h0123_4567_89AB_CDEF;
        img[15] = 64'hDEAD_BEEF_0000_0001;
        apply_img();
        base = wq.size();
        request_event("hit", ts1);
        wait_words(base + 35, "hit");
        check_packet("hit", base, 24'd4, ts1, 16'h8008);
        repeat (3) @(negedge clk);
        chk("hit_cnt", 64'(event_count), 64'(5));

        // Reset while DATA word 10 is on the bus
        set_pattern_a();
        request_event("rstmid", ts1);
        t = 0;
        while (!(m_tvalid && m_tdata == 32'd10) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("rstmid_word10", 64'(m_tvalid && m_tdata == 32'd10), 64'(1));
        #1 aresetn = 1'b0;
        #1;
        chk("rstmid_ctl", 64'({event_saved, m_tvalid, m_tlast, busy}), 64'(0));
        chk("rstmid_tdata", 64'(m_tdata), 64'(0));
        chk("rstmid_cnt", 64'({event_count, dropped_count}), 64'(0));
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
        sz = wq.size();
        repeat (5) @(negedge clk);
        chk("rstmid_no_more", 64'(wq.size()), 64'(sz));
        chk("rstmid_no_last", 64'(wq[sz - 1][32]), 64'(0));

        // Disabled: three events are acknowledged and dropped
        enable = 1'b0;
        p0 = saved_pulses;
        base = wq.size();
        for (int k = 0; k < 3; k++) request_event($sformatf("drop%0d", k), ts1);
        repeat (4) @(negedge clk);
        chk("drop_pulses", 64'(saved_pulses - p0), 64'(3));
        chk("drop_width", 64'(saved_cycles), 64'(saved_pulses));
        chk("drop_count", 64'(dropped_count), 64'(3));
        chk("drop_no_stream", 64'(wq.size()), 64'(base));
        chk("drop_busy", 64'(busy), 64'(0));

        // Re-enabled: packet after reset carries event field 0
        enable = 1'b1;
        request_event("reen", ts1);
        wait_words(base + 35, "reen");
        check_packet("reen", base, 24'd0, ts1, 16'hFFFF);
        repeat (3) @(negedge clk);
        chk("reen_cnt", 64'(event_count), 64'(1));
        chk("reen_drop_kept", 64'(dropped_count), 64'(3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/event_readout_ctrl.md
# event_readout_ctrl

Readout controller between the `sampler` block and the downstream stream sink (FIFO/UART bridge). It completes the `event_ready`/`event_saved` handshake with the sampler and latches the 16×64-bit event into a local buffer. It then emits the event as a framed 32-bit AXI-Stream packet: header, timestamp, channel data, and trailer. When readout is disabled, it acknowledges and counts dropped events so the sampler never stalls.

## Interface
- `CHANNELS`, default 16: number of channels in the event.
- `SAMPLES`, default 64: bits per channel; must be a multiple of 32.
- `clk` in, 1: system clock, shared with `sampler`.
- `aresetn` in, 1: reset, asynchronous, active-low; clock `clk`.
- `enable` in, 1: readout enable; sampled only in IDLE.
- `event_ready` in, 1: from sampler; an event is valid and held.
- `evento` in, [CHANNELS-1:0][SAMPLES-1:0]: event payload from sampler.
- `event_saved` out, 1: one-cycle acknowledge to sampler; registered.
- `m_tdata` out, 32: stream data.
- `m_tvalid` out, 1: stream valid.
- `m_tready` in, 1: stream ready.
- `m_tlast` out, 1: high on the trailer word.
- `event_count` out, 24: number of packets fully transmitted; wraps.
- `dropped_count` out, 16: events acknowledged while disabled; saturates at 0xFFFF.
- `busy` out, 1: high in every state except IDLE.

## Operation
- **Timestamp.** A free-running 32-bit cycle counter starts at 0 after reset and wraps at 2^32.
- **FSM states:** IDLE, ACK, DROP, HEADER, TSTAMP, DATA, TRAILER.
- **IDLE, enabled event.** If `event_ready` and `enable` are both 1:
  - latch `evento` into the buffer;
  - latch the timestamp into `ts_q`;
  - compute `hit_mask[c]` as the OR-reduce of channel c;
  - go to ACK.
- **IDLE, disabled event.** If `event_ready`=1 and `enable`=0, go to DROP. The buffer is untouched.
- **ACK.** `event_saved`=1 for this cycle only. Next state is HEADER.
- **DROP.** `event_saved`=1 for this cycle only. `dropped_count` increments (saturating). Next state is IDLE.
- **Packet format.** 35 words, all advanced only on a handshake (`m_tvalid` && `m_tready`):
  - HEADER: `m_tdata` = {8'hA5, `event_count`}.
  - TSTAMP: `m_tdata` = `ts_q`.
  - DATA: 32 words. For channel c = 0..15, emit `buf[c][31:0]` then `buf[c][63:32]`. The word index counter is 5 bits, 0..31; leave DATA on the handshake at index 31.
  - TRAILER: `m_tdata` = {8'h5A, 8'h00, `hit_mask`}, with `m_tlast`=1.
- **Packet completion.** On the TRAILER handshake, `event_count` increments (wraps at 2^24) and the FSM returns to IDLE.
- **Stream rules:**
  - `m_tvalid`=1 in HEADER, TSTAMP, DATA and TRAILER, and 0 elsewhere.
  - While `m_tvalid`=1 and `m_tready`=0, `m_tdata` and `m_tlast` are held stable.
  - `m_tvalid` is never withdrawn before its handshake.
- **Enable changes.** A change of `enable` mid-packet has no effect; the packet completes.
- **Event arriving mid-packet.** A new `event_ready` during a packet is not acknowledged until IDLE. The sampler holds it; no event is lost or duplicated.
- **No re-capture.** IDLE never re-captures the same event. `event_ready` falls one cycle after `event_saved`, which is before HEADER ends.
- **Reset mid-packet.** The packet is abandoned. No `m_tlast` is produced. All state clears.

## Timing
- **Reset values:**
  - `event_saved`, `m_tvalid`, `m_tlast`, `busy` = 0;
  - `m_tdata` = 0;
  - `event_count`, `dropped_count` = 0;
  - FSM in IDLE; timestamp = 0.
- **Capture latency.** If `event_ready` is seen at edge N:
  - `event_saved`=1 during cycle N+1;
  - the first `m_tvalid` (HEADER) is at cycle N+2.
- **Drop latency.** A dropped event gives `event_saved`=1 at N+1 and IDLE again at N+2.
- **Throughput.** With `m_tready` held at 1, the packet takes 35 consecutive cycles. A minimum of 37 cycles separates consecutive `event_saved` pulses (ACK + 35 words + 1 IDLE).
- **Timestamp value.** `ts_q` equals the counter value in the cycle IDLE detected `event_ready`.
- **Registered outputs.** All outputs are registered; there is no combinational path from `m_tready` to `m_tvalid`.

## Test plan
- **Single event.** After reset, drive `evento[c]` = {32'(c*2+1), 32'(c*2)} and pulse the sampler to `event_ready`, with `m_tready`=1. Expect:
  - `event_saved` for exactly 1 cycle;
  - 35 words: 0xA5000000, then the timestamp, then 0,1,2,…,31, then 0x5A00FFFF with `m_tlast`;
  - `event_count`=1 afterwards.
- **Backpressure.** Same event as above, with `m_tready` toggling pseudo-randomly (30% high). Expect:
  - an identical word sequence;
  - data stable whenever stalled;
  - no `m_tvalid` gaps inside the packet.
- **Disabled.** With `enable`=0, send 3 events. Expect:
  - 3 `event_saved` pulses;
  - `dropped_count`=3 and no stream output.
  Then re-enable, send 1 event, and expect a header event field of 0.
- **Back-to-back events.** Assert a second `event_ready` during DATA of packet 1. Expect:
  - the second `event_saved` only after packet 1's `m_tlast`;
  - the packet 2 header equal to 0xA5000001.
- **Hit mask.** Only channels 3 and 15 are nonzero. Expect the trailer 0x5A008008.
- **Reset mid-packet.** Assert `aresetn`=0 at DATA word 10. Expect:
  - all outputs 0 immediately;
  - `event_count`=0.
  Then a new event is read out correctly with an event field of 0.
